// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch unit (master) and imem (slave).
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input  imem_ready, imem_rdata);
    modport slave  (input  imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// IF stage with IF/ID register: PC, imem req/ready handshake, branch/jump redirect.
// Optional delay-slot behaviour is enabled by defining BRANCH_DELAY_SLOT_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      i_stall,
    input  logic                      i_branch_taken,
    input  logic [31:0]               i_branch_offset,
    input  logic                      i_jump,
    input  logic [25:0]               i_jump_target,
    instr_fetch_unit_if.master        imem,
    output logic [31:0]               o_instr,
    output logic [15:0]               o_imm16,
    output logic [31:0]               o_pc_plus4,
    output logic                      o_instr_valid
);

    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
`ifdef BRANCH_DELAY_SLOT_EN
    localparam logic [1:0] DSLOT = 2'd2;
`endif

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc_plus4;
    logic        r_instr_valid;
`ifdef BRANCH_DELAY_SLOT_EN
    logic [31:0] r_pend_pc;
`endif

    logic        w_req;
    logic        w_accept;
    logic        w_redir;
    logic [31:0] w_target;
    logic [31:0] w_pc_inc;
    logic        w_unused;

    assign w_req    = (r_state != BOOT) && !i_stall;
    assign w_accept = w_req && imem.imem_ready;
    // Redirects only come from decode once a live instruction exists, i.e. in FETCH.
    assign w_redir  = (r_state == FETCH) && (i_jump || i_branch_taken);
    assign w_target = i_jump ? {r_pc_plus4[31:28], i_jump_target, 2'b00}
                             : r_pc_plus4 + {i_branch_offset[29:0], 2'b00};
    assign w_pc_inc = r_pc + 32'd4;
    assign w_unused = ^i_branch_offset[31:30];

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_pc;
    assign o_instr        = r_instr;
    assign o_imm16        = r_instr[15:0];
    assign o_pc_plus4     = r_pc_plus4;
    assign o_instr_valid  = r_instr_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= BOOT;
            r_pc          <= RESET_PC;
            r_instr       <= 32'h0;
            r_pc_plus4    <= 32'h0;
            r_instr_valid <= 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
            r_pend_pc     <= RESET_PC;
`endif
        end else begin
            if (r_state == BOOT)
                r_state <= FETCH;
`ifdef BRANCH_DELAY_SLOT_EN
            if (w_redir) begin
                if (w_accept) begin
                    r_instr       <= imem.imem_rdata;
                    r_instr_valid <= 1'b1;
                    r_pc_plus4    <= w_pc_inc;
                    r_pc          <= w_target;
                end else begin
                    // Let the in-flight slot fetch finish before jumping.
                    r_pend_pc <= w_target;
                    r_state   <= DSLOT;
                end
            end else if (w_accept) begin
                r_instr       <= imem.imem_rdata;
                r_instr_valid <= 1'b1;
                r_pc_plus4    <= w_pc_inc;
                if (r_state == DSLOT) begin
                    r_pc    <= r_pend_pc;
                    r_state <= FETCH;
                end else begin
                    r_pc <= w_pc_inc;
                end
            end
`else
            if (w_redir) begin
                r_pc          <= w_target;
                r_instr       <= 32'h0;
                r_instr_valid <= 1'b0;
            end else if (w_accept) begin
                r_instr       <= imem.imem_rdata;
                r_instr_valid <= 1'b1;
                r_pc_plus4    <= w_pc_inc;
                r_pc          <= w_pc_inc;
            end
`endif
        end
    end

endmodule
